// File: rtl/tb_scoreboard_if.sv
// Expected/actual handshake bundle between a unit-level bench driver and tb_scoreboard.
interface tb_scoreboard_if #(
  parameter int unsigned WIDTH = 32
);
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic [WIDTH-1:0] cmp_mask;

  modport master (
    output exp_valid, exp_data, act_valid, act_data, cmp_mask,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data, cmp_mask,
    output exp_ready
  );
endinterface

// File: rtl/tb_scoreboard.sv
// Scoreboard: queues expected values, compares DUT results against the queue head
// under a bit mask, and tracks pass/fail counts, sticky errors, watchdog and completion.
module tb_scoreboard #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned N_TESTS      = 1000,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  tb_scoreboard_if.slave     sb,
  output logic [31:0]        pass_count,
  output logic [31:0]        fail_count,
  output logic               err_unexpected,
  output logic               err_timeout,
  output logic [WIDTH-1:0]   first_fail_exp,
  output logic [WIDTH-1:0]   first_fail_act,
  output logic               done,
  output logic               failed
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WDW-1:0]   wd_cnt;
  logic             exp_ready_int;

  logic             in_run, launch, empty, full, push, pop, match, any_err, reached;
  logic [WIDTH-1:0] head;
  logic [32:0]      tally;

  assign in_run  = (state == RUN);
  assign launch  = start && !in_run;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Ready is taken from the pre-pop occupancy, so a pop never frees a slot in the same cycle.
  assign push    = sb.exp_valid && exp_ready_int;
  assign pop     = in_run && sb.act_valid && !empty;
  assign head    = mem[rd_ptr];
  assign match   = ((head ^ sb.act_data) & sb.cmp_mask) == '0;
  assign any_err = (fail_count != '0) || err_unexpected || err_timeout;
  assign tally   = {1'b0, pass_count} + {1'b0, fail_count};
  assign reached = tally >= 33'(N_TESTS);

  assign sb.exp_ready = exp_ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (start) state_n = RUN;
      RUN: begin
        if ((STOP_ON_FAIL != 0) && any_err) state_n = FAIL;
        else if (reached)                   state_n = DONE;
      end
      DONE, FAIL: if (start) state_n = RUN;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    exp_ready_int = in_run && !full;
    done          = (state == DONE);
    failed        = (state == FAIL) || ((state == DONE) && any_err);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sb.exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      wd_cnt         <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      err_unexpected <= 1'b0;
      err_timeout    <= 1'b0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (launch) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      wd_cnt         <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      err_unexpected <= 1'b0;
      err_timeout    <= 1'b0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
    end else if (in_run) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (sb.act_valid) begin
        if (empty) begin
          err_unexpected <= 1'b1;
        end else if (match) begin
          if (pass_count != '1) pass_count <= pass_count + 32'd1;
        end else begin
          // Fail counter only saturates, never wraps, so zero marks "no mismatch yet".
          if (fail_count == '0) begin
            first_fail_exp <= head;
            first_fail_act <= sb.act_data;
          end
          if (fail_count != '1) fail_count <= fail_count + 32'd1;
        end
      end

      if (sb.act_valid || empty) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WDW'(TIMEOUT)) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WDW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
endmodule

// File: doc/tb_scoreboard.md
# tb_scoreboard

Parametrised, self-checking scoreboard for the SoC's unit-level benches. Expected values are queued in an internal FIFO and each DUT result is compared against the queue head. Pass/fail counts, sticky error flags, a stall watchdog and a completion state machine replace hand-written per-test assertions. It sits beside the DUT inside a `*_tb` top and drives `$finish` decisions through `done`/`failed`, but is written as synthesizable RTL so it can also be placed on an FPGA build.

## Interface
- `WIDTH`, 32: data width of expected/actual values.
- `DEPTH`, 16: expected-FIFO entries; power of two, ≥2.
- `N_TESTS`, 1000: number of comparisons that completes a run.
- `TIMEOUT`, 1024: idle cycles allowed while FIFO non-empty before timeout error; ≥1.
- `STOP_ON_FAIL`, 1: 1 = enter FAIL on first error; 0 = keep counting to `N_TESTS`.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; IDLE→RUN.
- `exp_valid`  in  1  push expected value.
- `exp_data`  in  WIDTH  expected value.
- `exp_ready`  out  1  FIFO not full and state is RUN.
- `act_valid`  in  1  DUT result present this cycle.
- `act_data`  in  WIDTH  DUT result.
- `cmp_mask`  in  WIDTH  bit=1 means compared; sampled with `act_valid`.
- `pass_count`  out  32  matching comparisons.
- `fail_count`  out  32  mismatching comparisons.
- `err_unexpected`  out  1  sticky: `act_valid` with FIFO empty.
- `err_timeout`  out  1  sticky: watchdog expired.
- `first_fail_exp` / `first_fail_act`  out  WIDTH each  captured on first mismatch.
- `done`  out  1  state DONE.
- `failed`  out  1  state FAIL, or DONE with any error/fail.

## Operation
- States: IDLE, RUN, DONE, FAIL.
  - IDLE→RUN on `start`. Entering RUN clears counters, sticky flags, captures, FIFO and watchdog.
  - RUN→DONE when `pass_count + fail_count` reaches `N_TESTS`.
  - RUN→FAIL on any error when `STOP_ON_FAIL=1`.
  - DONE and FAIL are terminal until `start` (→RUN) or reset.
- Push: `exp_valid && exp_ready`. The value is written at tail. Pushes outside RUN are ignored.
- Compare: `act_valid` in RUN.
  - FIFO non-empty: pop head. Match iff `((head ^ act_data) & cmp_mask) == 0`. Match increments `pass_count`; mismatch increments `fail_count`.
  - First mismatch since start latches `first_fail_exp`=head and `first_fail_act`=`act_data`.
  - FIFO empty: set `err_unexpected`; no count change.
- A push and a pop in the same cycle are both honoured. The pushed value is not visible to that cycle's compare, so a push into an empty FIFO with simultaneous `act_valid` flags `err_unexpected`.
- Full: `exp_ready`=0; a simultaneous pop does not open a slot that cycle. Pointers wrap modulo `DEPTH`; occupancy counter is `$clog2(DEPTH)+1` bits.
- Watchdog:
  - Counts cycles in RUN with FIFO non-empty and no `act_valid`.
  - Resets on any `act_valid` or when the FIFO is empty.
  - Reaching `TIMEOUT` sets `err_timeout` and the counter holds.
- Counters saturate at 2^32−1.
- `act_valid` outside RUN is ignored.

## Timing
- Reset values: all outputs 0 (`exp_ready`=0, `done`=0, `failed`=0), state IDLE, FIFO empty.
- Asynchronous reset mid-run discards everything immediately.
- `start` sampled at edge N: RUN and `exp_ready` visible after edge N.
- Compare latency 1: `act_valid` at edge N updates counts, flags and captures after edge N.
- `done`/`failed` rise the cycle after the deciding compare or error, i.e. after edge N+1.
- Watchdog: FIFO non-empty with no `act_valid` for `TIMEOUT` consecutive edges sets `err_timeout` after the `TIMEOUT`-th edge.

## Test plan
- **Clean run:** WIDTH=32, N_TESTS=4. start; push 0x1,0x2,0x3,0x4; return the same four values → pass_count=4, fail_count=0, `done`=1, `failed`=0 one cycle after the 4th compare.
- **Mismatch with STOP_ON_FAIL=1:** push 0xA5, 0x5A; act 0xA5 then 0x00 → pass=1, fail=1, first_fail_exp=0x5A, first_fail_act=0x00, FAIL state, `failed`=1.
- **Mask:** push 0xFF00; act 0xFF0F with cmp_mask=0xFFF0 → pass=1. The same act with mask 0xFFFF → fail=1.
- **Full/empty:** DEPTH=4. Push 5 values → `exp_ready` falls after the 4th, 5th push dropped. `act_valid` on an empty FIFO → `err_unexpected`=1. Push and act on an empty FIFO in one cycle → `err_unexpected`=1, occupancy 1.
- **Timeout:** TIMEOUT=8, STOP_ON_FAIL=0. Push 1 value, hold `act_valid`=0 for 8 cycles → `err_timeout`=1 after the 8th edge, state remains RUN.
- **Reset mid-run:** deassert `rst_n` asynchronously between edges with 3 entries queued and pass=2 → all outputs 0 immediately, IDLE. A later start gives an empty FIFO.
